// File: rtl/elevator_pkg.sv
// ============================================================================
// elevator_pkg : shared types, defaults and call-direction helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package elevator_pkg;

  localparam int DEF_NUM_FLOORS = 6;
  localparam int MAX_FLOORS     = 32;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MOVE_UP    = 3'd1,
    MOVE_DOWN  = 3'd2,
    DOOR_OPEN  = 3'd3,
    DOOR_CLOSE = 3'd4
  } state_e;

  // Floor vectors are zero-extended to MAX_FLOORS; currentFloor is one-hot.
  function automatic logic callsAbove(input logic [MAX_FLOORS-1:0] pending,
                                      input logic [MAX_FLOORS-1:0] currentFloor);
    logic [MAX_FLOORS-1:0] mask;
    mask = ~((currentFloor << 1) - MAX_FLOORS'(1));
    return |(pending & mask);
  endfunction

  function automatic logic callsBelow(input logic [MAX_FLOORS-1:0] pending,
                                      input logic [MAX_FLOORS-1:0] currentFloor);
    logic [MAX_FLOORS-1:0] mask;
    mask = currentFloor - MAX_FLOORS'(1);
    return |(pending & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_timer.sv
// ============================================================================
// elevator_timer : loadable down-counter shared by travel, open and close phases
// Rev 1.0
// ============================================================================
`default_nettype none

module elevator_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_enable,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;

  // i_clear restarts the phase by loading its length minus one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= i_load_val;
    end else if (i_enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/elevator_scheduler.sv
// ============================================================================
// elevator_scheduler : single-car SCAN elevator controller with door sequencing
// Optional macro ELEV_REOPEN_EN: obstruction or local call reopens a closing door.
// Rev 1.0
// ============================================================================
`default_nettype none

module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8,
  parameter int CLOSE_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] callReq,
  input  logic                  doorHold,
  input  logic                  obstruct,
  output logic [NUM_FLOORS-1:0] currentFloor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  moveUp,
  output logic                  moveDown,
  output logic                  doorOpen,
  output logic                  close
);

  localparam int MAX_A   = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int MAX_CYC = (MAX_A > CLOSE_CYCLES) ? MAX_A : CLOSE_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_e                r_state, w_next;
  logic [NUM_FLOORS-1:0] r_floor, w_floor_next;
  logic [NUM_FLOORS-1:0] r_pending, w_req, w_clr;
  logic                  r_dir_up, w_dir_next;
  logic                  w_above, w_below, w_done, w_load, w_enable;
  logic [TW-1:0]         w_load_val;

  // Same-cycle calls take part in decisions so an arrival at a new floor stops the car.
  assign w_req   = r_pending | callReq;
  assign w_above = callsAbove(MAX_FLOORS'(w_req), MAX_FLOORS'(r_floor));
  assign w_below = callsBelow(MAX_FLOORS'(w_req), MAX_FLOORS'(r_floor));

  always_comb begin
    w_next       = r_state;
    w_floor_next = r_floor;
    w_dir_next   = r_dir_up;
    case (r_state)
      IDLE: begin
        if (|(w_req & r_floor)) begin
          w_next = DOOR_OPEN;
        end else if (r_dir_up && w_above) begin
          w_next = MOVE_UP;
        end else if (!r_dir_up && w_below) begin
          w_next = MOVE_DOWN;
        end else if (w_above) begin
          w_next     = MOVE_UP;
          w_dir_next = 1'b1;
        end else if (w_below) begin
          w_next     = MOVE_DOWN;
          w_dir_next = 1'b0;
        end
      end
      MOVE_UP: begin
        if (!w_above || r_floor[NUM_FLOORS-1]) begin
          w_next = IDLE;
        end else if (w_done) begin
          w_floor_next = r_floor << 1;
          if (|(w_req & w_floor_next)) begin
            w_next = DOOR_OPEN;
          end else if (!callsAbove(MAX_FLOORS'(w_req), MAX_FLOORS'(w_floor_next))) begin
            w_next = IDLE;
          end
        end
      end
      MOVE_DOWN: begin
        if (!w_below || r_floor[0]) begin
          w_next = IDLE;
        end else if (w_done) begin
          w_floor_next = r_floor >> 1;
          if (|(w_req & w_floor_next)) begin
            w_next = DOOR_OPEN;
          end else if (!callsBelow(MAX_FLOORS'(w_req), MAX_FLOORS'(w_floor_next))) begin
            w_next = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        if (!doorHold && w_done) begin
          w_next = DOOR_CLOSE;
        end
      end
      DOOR_CLOSE: begin
`ifdef ELEV_REOPEN_EN
        if (obstruct || |(w_req & r_floor)) begin
          w_next = DOOR_OPEN;
        end else if (w_done) begin
          w_next = IDLE;
        end
`else
        if (w_done) begin
          w_next = IDLE;
        end
`endif
      end
      default: w_next = IDLE;
    endcase
  end

`ifndef ELEV_REOPEN_EN
  logic w_unused_obstruct;
  assign w_unused_obstruct = obstruct;
`endif

  assign w_clr = ((w_next == DOOR_OPEN) || (r_state == DOOR_OPEN)) ? w_floor_next : '0;

  // Any phase change, floor step or door hold restarts the shared timer.
  assign w_load   = (w_next != r_state) || (w_floor_next != r_floor) ||
                    ((r_state == DOOR_OPEN) && doorHold);
  assign w_enable = (r_state != IDLE);

  always_comb begin
    case (w_next)
      MOVE_UP, MOVE_DOWN: w_load_val = TW'(TRAVEL_CYCLES - 1);
      DOOR_OPEN:          w_load_val = TW'(DOOR_CYCLES - 1);
      default:            w_load_val = TW'(CLOSE_CYCLES - 1);
    endcase
  end

  elevator_timer #(
    .WIDTH      (TW)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (w_load),
    .i_load_val (w_load_val),
    .i_enable   (w_enable),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_floor   <= NUM_FLOORS'(1);
      r_pending <= '0;
      r_dir_up  <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_floor   <= w_floor_next;
      r_pending <= w_req & ~w_clr;
      r_dir_up  <= w_dir_next;
    end
  end

  assign currentFloor = r_floor;
  assign pending      = r_pending;
  assign moveUp       = (r_state == MOVE_UP);
  assign moveDown     = (r_state == MOVE_DOWN);
  assign doorOpen     = (r_state == DOOR_OPEN);
  assign close        = (r_state == DOOR_CLOSE);

endmodule

`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
// ============================================================================
// tb_elevator_scheduler : directed scenarios plus random calls against a floor-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_elevator_scheduler;

  localparam int NF = 6;
  localparam int TC = 4;
  localparam int DC = 8;
  localparam int CC = 2;
  localparam int S_IDLE = 0, S_UP = 1, S_DN = 2, S_OPEN = 3, S_CLOSE = 4;
  localparam logic [NF-1:0] NOC = '0;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NF-1:0] callReq;
  logic          doorHold, obstruct;
  logic [NF-1:0] currentFloor, pending;
  logic          moveUp, moveDown, doorOpen, close;

  int n_vec = 0;
  int n_err = 0;

  int            m_floor, m_st, m_cnt;
  logic [NF-1:0] m_pend;
  bit            m_dir;

  elevator_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .callReq      (callReq),
    .doorHold     (doorHold),
    .obstruct     (obstruct),
    .currentFloor (currentFloor),
    .pending      (pending),
    .moveUp       (moveUp),
    .moveDown     (moveDown),
    .doorOpen     (doorOpen),
    .close        (close)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit any_above(input logic [NF-1:0] v, input int f);
    for (int i = f + 1; i < NF; i++) if (v[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(input logic [NF-1:0] v, input int f);
    for (int i = 0; i < f; i++) if (v[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_pend = '0; m_dir = 1'b1; m_st = S_IDLE; m_cnt = 0;
  endtask

  task automatic model_step(input logic [NF-1:0] c, input logic h, input logic o);
    logic [NF-1:0] reqv;
    int nst, nfl;
    bit ndir, reopen;
    reqv = m_pend | c;
    nst = m_st; nfl = m_floor; ndir = m_dir;
`ifdef ELEV_REOPEN_EN
    reopen = o || reqv[m_floor];
`else
    reopen = o & 1'b0;
`endif
    case (m_st)
      S_IDLE: begin
        if (reqv[m_floor])                            nst = S_OPEN;
        else if (m_dir && any_above(reqv, m_floor))   nst = S_UP;
        else if (!m_dir && any_below(reqv, m_floor))  nst = S_DN;
        else if (any_above(reqv, m_floor)) begin nst = S_UP; ndir = 1'b1; end
        else if (any_below(reqv, m_floor)) begin nst = S_DN; ndir = 1'b0; end
      end
      S_UP: begin
        if (m_floor == NF - 1 || !any_above(reqv, m_floor)) nst = S_IDLE;
        else if (m_cnt == TC - 1) begin
          nfl = m_floor + 1;
          nst = reqv[nfl] ? S_OPEN : (any_above(reqv, nfl) ? S_UP : S_IDLE);
        end
      end
      S_DN: begin
        if (m_floor == 0 || !any_below(reqv, m_floor)) nst = S_IDLE;
        else if (m_cnt == TC - 1) begin
          nfl = m_floor - 1;
          nst = reqv[nfl] ? S_OPEN : (any_below(reqv, nfl) ? S_DN : S_IDLE);
        end
      end
      S_OPEN:  if (!h && m_cnt == DC - 1) nst = S_CLOSE;
      default: begin
        if (reopen)               nst = S_OPEN;
        else if (m_cnt == CC - 1) nst = S_IDLE;
      end
    endcase
    if (nst == S_OPEN || m_st == S_OPEN) reqv[nfl] = 1'b0;
    m_cnt  = (nst != m_st || nfl != m_floor || (m_st == S_OPEN && h)) ? 0 : m_cnt + 1;
    m_st   = nst;
    m_floor = nfl;
    m_dir  = ndir;
    m_pend = reqv;
  endtask

  task automatic check_all();
    logic [3:0] exp_out;
    exp_out = {m_st == S_UP, m_st == S_DN, m_st == S_OPEN, m_st == S_CLOSE};
    check("floor",   32'(currentFloor), 32'(1) << m_floor);
    check("pending", 32'(pending), 32'(m_pend));
    check("outputs", 32'({moveUp, moveDown, doorOpen, close}), 32'(exp_out));
  endtask

  task automatic tick(input logic [NF-1:0] c, input logic h, input logic o);
    callReq = c; doorHold = h; obstruct = o;
    @(posedge clk);
    model_step(c, h, o);
    #1 check_all();
  endtask

  initial begin
    logic [NF-1:0] rc;
    logic          rh, ro;
    callReq = '0; doorHold = 1'b0; obstruct = 1'b0; reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_floor",   32'(currentFloor), 32'd1);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_outputs", 32'({moveUp, moveDown, doorOpen, close}), 32'd0);
    reset_n = 1'b1;

    // Local call, long move up, SCAN reversal, door hold, obstruct in close.
    tick(6'b000001, 1'b0, 1'b0);
    check("t1_open", 32'(doorOpen), 32'd1);
    repeat (12) tick(NOC, 1'b0, 1'b0);
    tick(6'b001000, 1'b0, 1'b0);
    repeat (13) tick(NOC, 1'b0, 1'b0);
    check("t2_floor3", 32'(currentFloor), 32'b001000);
    repeat (12) tick(NOC, 1'b0, 1'b0);
    tick(6'b000001, 1'b0, 1'b0);
    tick(6'b100000, 1'b0, 1'b0);
    repeat (70) tick(NOC, 1'b0, 1'b0);
    tick(6'b000001, 1'b0, 1'b0);
    repeat (20) tick(NOC, 1'b1, 1'b0);
    repeat (14) tick(NOC, 1'b0, 1'b0);
    tick(6'b000001, 1'b0, 1'b0);
    repeat (8) tick(NOC, 1'b0, 1'b0);
    tick(NOC, 1'b0, 1'b1);
    repeat (12) tick(NOC, 1'b0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      rc = ($urandom_range(0, 9) == 0) ? NF'($urandom) : NOC;
      rh = ($urandom_range(0, 19) == 0);
      ro = ($urandom_range(0, 7) == 0);
      tick(rc, rh, ro);
    end

    // Asynchronous reset while travelling up past floor 3.
    reset_n = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(6'b100000, 1'b0, 1'b0);
    repeat (13) tick(NOC, 1'b0, 1'b0);
    check("t6_pre_up", 32'(moveUp), 32'd1);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_floor",   32'(currentFloor), 32'b000001);
    check("t6_pending", 32'(pending), 32'd0);
    check("t6_outputs", 32'({moveUp, moveDown, doorOpen, close}), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) tick(NOC, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
